// File: rtl/divmmc_pkg.sv
// Shared constants and helpers for the DivMMC-compatible mapper:
// I/O port numbers, automap trap addresses and the decoded bus-cycle record.
package divmmc_pkg;

  // I/O ports decoded on A[7:0]
  localparam logic [7:0] PORT_CTRL = 8'hE3;  // page / conmem / mapram
  localparam logic [7:0] PORT_CS   = 8'hE7;  // SPI chip selects
  localparam logic [7:0] PORT_SPI  = 8'hEB;  // SPI data

  // Opcode-fetch addresses that arm a deferred automap
  localparam logic [15:0] TRAP_RST00 = 16'h0000;
  localparam logic [15:0] TRAP_RST08 = 16'h0008;
  localparam logic [15:0] TRAP_RST38 = 16'h0038;
  localparam logic [15:0] TRAP_LOAD  = 16'h04C6;
  localparam logic [15:0] TRAP_SAVE  = 16'h0562;
  localparam logic [15:0] TRAP_NMI   = 16'h0066;

  // 0x3Dxx maps instantly; 0x1FF8..0x1FFF un-arms the overlay
  localparam logic [7:0]  ROM3D_HI  = 8'h3D;
  localparam logic [15:0] EXIT_BASE = 16'h1FF8;

  // RAM page that stands in for the ROM once MAPRAM is set
  localparam int ROM_PAGE3 = 3;

  // One flag per Z80 cycle type that the block reacts to
  typedef struct packed {
    logic io_we;
    logic io_rd;
    logic op_rd;
  } bus_cycle_t;

  function automatic logic is_entry_trap(input logic [15:0] a);
    return (a == TRAP_RST00) || (a == TRAP_RST08) || (a == TRAP_RST38) ||
           (a == TRAP_LOAD)  || (a == TRAP_SAVE);
  endfunction

  function automatic logic is_exit_range(input logic [15:0] a);
    return a[15:3] == EXIT_BASE[15:3];
  endfunction

endpackage

// File: rtl/divmmc_plus_if.sv
// Z80-side bus of the DivMMC mapper.
//
// Handshake: the Z80 strobes carry no ready signal. A cycle qualifier
// (I/O write, I/O read, opcode fetch) counts as valid on the first clk it
// is seen true; the block is always ready, so the access is taken exactly
// once on that clk. A further access of the same kind needs the qualifier
// to go false for at least one clk in between.
interface divmmc_plus_if;
  logic [15:0] A;
  logic        nWR;
  logic        nRD;
  logic        nMREQ;
  logic        nIORQ;
  logic        nM1;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;

  modport master (
    output A, nWR, nRD, nMREQ, nIORQ, nM1, din,
    input  dout, dout_oe
  );

  modport slave (
    input  A, nWR, nRD, nMREQ, nIORQ, nM1, din,
    output dout, dout_oe
  );
endinterface

// File: rtl/divmmc_plus_spi.sv
// SPI mode-0 byte engine: one byte out on mosi, one byte in from miso,
// MSB first, SCK half-period of SPI_DIV clks. Starts are ignored while a
// transfer is running.
module spi_byte_engine #(
  parameter int SPI_DIV = 2
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic [0:0] state_dbg
);

  localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    half_cnt;   // SCK half-periods completed, 16 per byte
  logic [6:0]    tx_sh;      // bits still to be presented after the current one
  logic [7:0]    rx_sh;

  assign busy      = (state == ST_XFER);
  assign state_dbg = state;

  // Divider, half-period counter and shift registers; srst aborts at once
  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx       <= 8'hFF;
      sck      <= 1'b0;
      mosi     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_XFER;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sh    <= tx[6:0];
            mosi     <= tx[7];
            sck      <= 1'b0;
          end
        end
        ST_XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 4'd1;
            if (!sck) begin
              // rising edge: the card's bit is taken here
              sck   <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
            end else begin
              // falling edge: next bit out, or finish after the eighth
              sck <= 1'b0;
              if (half_cnt == 4'd15) begin
                state <= ST_IDLE;
                rx    <= rx_sh;
                mosi  <= 1'b1;
              end else begin
                mosi  <= tx_sh[6];
                tx_sh <= {tx_sh[5:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/divmmc_plus.sv
// DivMMC-compatible overlay mapper and SPI host. Decodes Z80 cycles into
// single-shot strobes, keeps the paging registers and automap state, and
// drives the SPI byte engine from ports 0xE7/0xEB.
module divmmc_plus
  import divmmc_pkg::*;
#(
  parameter int PAGE_BITS = 4,
  parameter int NUM_CS    = 2,
  parameter int SPI_DIV   = 2,
  parameter int NMI_GATED = 1
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic                  enabled,
  divmmc_plus_if.slave          bus,
  input  logic                  nmi_button,
  output logic                  active,
  output logic [PAGE_BITS+13:0] mapped_addr,
  output logic                  mem_we,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_busy,
  output logic [0:0]            dbg_spi_state
);

  localparam logic [PAGE_BITS-1:0] PAGE3 = PAGE_BITS'(ROM_PAGE3);

  // enabled=0 acts as a soft reset for everything but mapram
  logic soft_rst;
  assign soft_rst = !nRESET || !enabled;

  // ---------------------------------------------------------------------
  // Cycle qualifiers and first-clk strobes
  // ---------------------------------------------------------------------
  bus_cycle_t lvl, lvl_q, stb;

  // Raw qualifiers straight from the Z80 strobes
  always_comb begin
    lvl.io_we = !bus.nIORQ &  bus.nRD & !bus.nWR &  bus.nM1;
    lvl.io_rd = !bus.nIORQ & !bus.nRD &  bus.nWR &  bus.nM1;
    lvl.op_rd = !bus.nMREQ & !bus.nRD &  bus.nWR & !bus.nM1;
  end

  // Remember last clk's qualifiers so each cycle acts only once
  always_ff @(posedge clk) begin
    if (soft_rst) lvl_q <= '0;
    else          lvl_q <= lvl;
  end

  // Strobes are true only on the first clk of a qualified cycle
  always_comb begin
    stb.io_we = lvl.io_we & !lvl_q.io_we & !soft_rst;
    stb.io_rd = lvl.io_rd & !lvl_q.io_rd & !soft_rst;
    stb.op_rd = lvl.op_rd & !lvl_q.op_rd & !soft_rst;
  end

  logic [7:0] port;
  logic       wr_ctrl, wr_cs, wr_spi, rd_spi;
  assign port    = bus.A[7:0];
  assign wr_ctrl = stb.io_we && (port == PORT_CTRL);
  assign wr_cs   = stb.io_we && (port == PORT_CS);
  assign wr_spi  = stb.io_we && (port == PORT_SPI);
  assign rd_spi  = stb.io_rd && (port == PORT_SPI);

  // din bits above the page field and below bit 6 carry no function here
  logic unused_din;
  assign unused_din = ^bus.din;

  // ---------------------------------------------------------------------
  // Paging / automap registers
  // ---------------------------------------------------------------------
  logic [PAGE_BITS-1:0] page;
  logic                 conmem;
  logic                 mapram;
  logic                 armed;
  logic                 automap;
  logic                 nmi_pend;

  logic fetch_entry, fetch_nmi, fetch_3d, fetch_exit, nmi_ok;
  assign fetch_entry = stb.op_rd && is_entry_trap(bus.A);
  assign fetch_nmi   = stb.op_rd && (bus.A == TRAP_NMI);
  assign fetch_3d    = stb.op_rd && (bus.A[15:8] == ROM3D_HI);
  assign fetch_exit  = stb.op_rd && is_exit_range(bus.A);
  // a button pulse on the same clk as the fetch still counts
  assign nmi_ok      = (NMI_GATED == 0) || nmi_pend || nmi_button;

  // mapram is sticky: only the hard reset clears it
  always_ff @(posedge clk) begin
    if (!nRESET)                     mapram <= 1'b0;
    else if (wr_ctrl && bus.din[6])  mapram <= 1'b1;
  end

  // Control port, chip selects, NMI latch and the armed/automap pair
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      page     <= '0;
      conmem   <= 1'b0;
      armed    <= 1'b0;
      automap  <= 1'b0;
      nmi_pend <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      if (wr_ctrl) begin
        page   <= bus.din[PAGE_BITS-1:0];
        conmem <= bus.din[7];
      end
      if (wr_cs) spi_cs_n <= bus.din[NUM_CS-1:0];

      if (fetch_nmi)       nmi_pend <= 1'b0;
      else if (nmi_button) nmi_pend <= 1'b1;

      if (fetch_3d)                      armed <= 1'b1;
      else if (fetch_entry)              armed <= 1'b1;
      else if (fetch_nmi && nmi_ok)      armed <= 1'b1;
      else if (fetch_exit)               armed <= 1'b0;

      // 0x3Dxx maps straight away; other traps wait for the M1 to end
      if (fetch_3d)     automap <= 1'b1;
      else if (bus.nM1) automap <= armed;
    end
  end

  // ---------------------------------------------------------------------
  // Overlay address mapping (combinational)
  // ---------------------------------------------------------------------
  logic                 ram_sel;
  logic [PAGE_BITS-1:0] map_page;
  logic                 page_we;
  logic                 read_only3;

  assign active     = automap || conmem;
  assign read_only3 = mapram && !conmem;

  // Pick ROM, write-protected page 3 or the selected RAM page
  always_comb begin
    ram_sel  = 1'b0;
    map_page = '0;
    page_we  = 1'b0;
    if (bus.A[13]) begin
      ram_sel  = 1'b1;
      map_page = page;
      page_we  = !((page == PAGE3) && read_only3);
    end else if (read_only3) begin
      ram_sel  = 1'b1;
      map_page = PAGE3;
      page_we  = 1'b0;
    end
  end

  assign mapped_addr = {ram_sel, map_page, bus.A[12:0]};
  assign mem_we      = active && (bus.A[15:14] == 2'b00) && page_we;

  // ---------------------------------------------------------------------
  // SPI
  // ---------------------------------------------------------------------
  logic [7:0] rx_byte;
  logic       rd_spi_lvl;

  // A read of 0xEB returns the previous byte and clocks out a dummy 0xFF
  spi_byte_engine #(.SPI_DIV(SPI_DIV)) u_spi (
    .clk       (clk),
    .srst      (soft_rst),
    .start     (wr_spi || rd_spi),
    .tx        (rd_spi ? 8'hFF : bus.din),
    .rx        (rx_byte),
    .busy      (spi_busy),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .miso      (spi_miso),
    .state_dbg (dbg_spi_state)
  );

  assign rd_spi_lvl  = lvl.io_rd && (port == PORT_SPI) && !soft_rst;
  assign bus.dout    = rd_spi_lvl ? rx_byte : 8'hFF;
  assign bus.dout_oe = rd_spi_lvl;

endmodule

// File: tb/tb_divmmc_plus.sv
// Bench for divmmc_plus: reset values, mapping table, automap/NMI
// sequences, and SPI transfers checked through an rx scoreboard.
module tb_divmmc_plus;
  import divmmc_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        nRESET;
  logic        enabled;
  logic        nmi_button;
  logic        active;
  logic [17:0] mapped_addr;
  logic        mem_we;
  logic [1:0]  spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_busy;
  logic [0:0]  dbg_spi_state;

  divmmc_plus_if bus();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // loopback card: whatever goes out comes back
  assign spi_miso = spi_mosi;

  divmmc_plus #(
    .PAGE_BITS(4), .NUM_CS(2), .SPI_DIV(2), .NMI_GATED(1)
  ) dut (
    .clk           (clk),
    .nRESET        (nRESET),
    .enabled       (enabled),
    .bus           (bus.slave),
    .nmi_button    (nmi_button),
    .active        (active),
    .mapped_addr   (mapped_addr),
    .mem_we        (mem_we),
    .spi_cs_n      (spi_cs_n),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_busy      (spi_busy),
    .dbg_spi_state (dbg_spi_state)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.nIORQ = 1'b1; bus.nMREQ = 1'b1; bus.nRD = 1'b1;
    bus.nWR   = 1'b1; bus.nM1   = 1'b1;
  endtask

  // strobe held for two clks so a level-sensitive decode would act twice
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk);
    bus.A = {8'h00, port}; bus.din = data; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data, output logic oe);
    @(negedge clk);
    bus.A = {8'h00, port}; bus.nIORQ = 1'b0; bus.nRD = 1'b0;
    #1;
    data = bus.dout;
    oe   = bus.dout_oe;
    @(negedge clk);
    bus_idle();
  endtask

  // opcode fetch; act_m1 is active seen while the M1 is still low
  task automatic fetch(input logic [15:0] addr, output logic act_m1);
    @(negedge clk);
    bus.A = addr; bus.nM1 = 1'b0; bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    @(negedge clk);
    act_m1 = active;
    bus_idle();
    @(negedge clk);
  endtask

  task automatic check_map(input string name, input logic [15:0] addr, input logic exp_act,
                           input logic chk_addr, input logic [17:0] exp_addr, input logic exp_we);
    @(negedge clk);
    bus.A = addr;
    #1;
    check({name, "_active"}, 32'(active), 32'(exp_act));
    if (chk_addr) check({name, "_addr"}, 32'(mapped_addr), 32'(exp_addr));
    check({name, "_we"}, 32'(mem_we), 32'(exp_we));
  endtask

  task automatic pulse_reset();
    @(negedge clk); nRESET = 1'b0;
    @(negedge clk); nRESET = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (spi_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (spi_busy) begin
      total++;
      bad++;
      $display("FAIL spi_idle_timeout: busy still %0d after %0d clks", spi_busy, n);
    end
  endtask

  task automatic read_rx(input string name);
    logic [7:0] d;
    logic       oe;
    logic [7:0] e;
    io_read(PORT_SPI, d, oe);
    check({name, "_oe"}, 32'(oe), 32'd1);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %0h want nothing (scoreboard empty)", name, d);
    end else begin
      total--;
      e = exp_q.pop_front();
      check(name, 32'(d), 32'(e));
    end
  endtask

  // ---------------- mapping vectors ----------------
  typedef struct {
    logic [7:0]  e3;
    logic [15:0] addr;
    logic        exp_act;
    logic        chk_addr;
    logic [17:0] exp_addr;
    logic        exp_we;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       m;
    logic [7:0] bits;
    logic [7:0] b;
    logic       prev_sck;
    int         bc;
    int         sp;

    // mapram=0, automap=0 for all rows
    vecs[0] = '{8'h85, 16'h2123, 1'b1, 1'b1, 18'h2A123, 1'b1};
    vecs[1] = '{8'h85, 16'h0100, 1'b1, 1'b1, 18'h00100, 1'b0};
    vecs[2] = '{8'h05, 16'h2123, 1'b0, 1'b0, 18'h00000, 1'b0};
    vecs[3] = '{8'h8A, 16'h3FFF, 1'b1, 1'b1, 18'h35FFF, 1'b1};
    vecs[4] = '{8'h83, 16'h2000, 1'b1, 1'b1, 18'h26000, 1'b1};
    vecs[5] = '{8'h81, 16'h4000, 1'b1, 1'b0, 18'h00000, 1'b0};
    vecs[6] = '{8'h8F, 16'h1FFF, 1'b1, 1'b1, 18'h01FFF, 1'b0};
    vecs[7] = '{8'h80, 16'hC000, 1'b1, 1'b0, 18'h00000, 1'b0};

    nRESET = 1'b0; enabled = 1'b1; nmi_button = 1'b0;
    bus.A = 16'h0000; bus.din = 8'h00;
    bus_idle();
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_active", 32'(active), 32'd0);
    check("rst_cs", 32'(spi_cs_n), 32'h3);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd1);
    check("rst_busy", 32'(spi_busy), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'hFF);
    check("rst_oe", 32'(bus.dout_oe), 32'd0);

    // mapping table
    for (int i = 0; i < 8; i++) begin
      io_write(PORT_CTRL, vecs[i].e3);
      check_map($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_act,
                vecs[i].chk_addr, vecs[i].exp_addr, vecs[i].exp_we);
    end

    // MAPRAM: page 3 stands in for ROM, read-only
    io_write(PORT_CTRL, 8'h43);
    io_write(PORT_CTRL, 8'h00);
    fetch(16'h0000, m);
    check("trap0000_m1", 32'(m), 32'd0);
    check_map("mapram_lo", 16'h0010, 1'b1, 1'b1, 18'h26010, 1'b0);
    check_map("mapram_p0", 16'h2010, 1'b1, 1'b1, 18'h20010, 1'b1);
    io_write(PORT_CTRL, 8'h03);
    check_map("mapram_p3", 16'h2010, 1'b1, 1'b1, 18'h26010, 1'b0);
    io_write(PORT_CTRL, 8'h00);

    // deferred off / deferred on / deferred off
    fetch(16'h1FFA, m);
    check("exit_m1", 32'(m), 32'd1);
    check("exit_after", 32'(active), 32'd0);
    fetch(16'h0038, m);
    check("trap0038_m1", 32'(m), 32'd0);
    check("trap0038_after", 32'(active), 32'd1);
    fetch(16'h1FF8, m);
    check("exit2_after", 32'(active), 32'd0);

    // enabled=0 clears conmem but mapram survives
    io_write(PORT_CTRL, 8'h85);
    @(negedge clk); enabled = 1'b0;
    repeat (2) @(negedge clk);
    enabled = 1'b1;
    check_map("dis_cleared", 16'h2123, 1'b0, 1'b0, 18'h00000, 1'b0);
    fetch(16'h3D00, m);
    check("rom3d_m1", 32'(m), 32'd1);
    check_map("mapram_sticky", 16'h0010, 1'b1, 1'b1, 18'h26010, 1'b0);

    // hard reset clears mapram
    pulse_reset();
    fetch(16'h3D00, m);
    check_map("mapram_cleared", 16'h0010, 1'b1, 1'b1, 18'h00010, 1'b0);

    // NMI-gated trap
    pulse_reset();
    fetch(16'h0066, m);
    check("nmi_nobutton", 32'(active), 32'd0);
    @(negedge clk); nmi_button = 1'b1;
    @(negedge clk); nmi_button = 1'b0;
    fetch(16'h0066, m);
    check("nmi_m1", 32'(m), 32'd0);
    check("nmi_after", 32'(active), 32'd1);
    fetch(16'h1FF8, m);
    fetch(16'h0066, m);
    check("nmi_pend_cleared", 32'(active), 32'd0);

    // SPI: chip select then a timed 0xA5 transfer
    io_write(PORT_CS, 8'hFE);
    check("cs_write", 32'(spi_cs_n), 32'h2);
    @(negedge clk);
    bus.A = {8'h00, PORT_SPI}; bus.din = 8'hA5; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus_idle();
    bc = 0; sp = 0; bits = 8'h00; prev_sck = 1'b0;
    for (int i = 0; i < 200 && spi_busy; i++) begin
      bc++;
      if (spi_sck && !prev_sck) begin
        sp++;
        bits = {bits[6:0], spi_mosi};
      end
      prev_sck = spi_sck;
      @(negedge clk);
    end
    check("spi_busy_clks", 32'(bc), 32'd32);
    check("spi_sck_pulses", 32'(sp), 32'd8);
    check("spi_mosi_bits", 32'(bits), 32'hA5);

    // read returns A5 and launches a 0xFF transfer
    read_rx("rx_a5");
    exp_q.push_back(8'hFF);
    check("rd_starts_xfer", 32'(spi_busy), 32'd1);
    io_write(PORT_SPI, 8'h3C);   // dropped: engine is busy
    wait_idle();
    read_rx("rx_after_drop");

    // reset in the middle of that read's transfer, with sck high
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(spi_busy), 32'd1);
    nRESET = 1'b0;
    @(negedge clk);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_cs", 32'(spi_cs_n), 32'h3);
    check("abort_busy", 32'(spi_busy), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd1);
    nRESET = 1'b1;

    // random bytes through the loopback
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      b = 8'($urandom_range(0, 255));
      io_write(PORT_SPI, b);
      exp_q.push_back(b);
      wait_idle();
      read_rx($sformatf("rx_rand%0d", i));
    end
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
